// File: rtl/bringup_pkg.sv
// bringup_pkg: shared state encodings and helpers for the bring-up sequencer
package bringup_pkg;
  localparam int MAX_PORTS = 8;
  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    LOCK_STABLE = 3'd1,
    HOLD        = 3'd2,
    RELEASE     = 3'd3,
    RUN         = 3'd4,
    REPORT      = 3'd5
  } seq_state_e;
  function automatic int max3(int a, int b, int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
  function automatic logic [2:0] lowest_idx(logic [MAX_PORTS-1:0] v);
    lowest_idx = '0;
    for (int i = MAX_PORTS - 1; i >= 0; i--) lowest_idx = v[i] ? 3'(i) : lowest_idx;
  endfunction
endpackage

// File: rtl/bringup_seq_if.sv
// bringup_seq_if: sequencer bus; master = board/PLL side, slave = sequencer
//   pll_locked, port_rst_req -> sequencer; port_rst, sys_ready, seq_state <- sequencer
interface bringup_seq_if #(parameter int NUM_PORTS = 2);
  logic                 pll_locked;
  logic [NUM_PORTS-1:0] port_rst_req;
  logic [NUM_PORTS-1:0] port_rst;
  logic                 sys_ready;
  logic [2:0]           seq_state;
  modport master (output pll_locked, port_rst_req, input port_rst, sys_ready, seq_state);
  modport slave (input pll_locked, port_rst_req, output port_rst, sys_ready, seq_state);
endinterface

// File: rtl/sync_bit.sv
// sync_bit: 2-flop synchroniser for one asynchronous input
//   clk, rst (async, active-high), d (async in), q (synchronised out)
module sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q <= 1'b0;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/bringup_seq.sv
// bringup_seq: PLL-lock gated, staggered per-port reset release with re-reset service
//   clk, rst (async, active-high); bus.slave: pll_locked, port_rst_req in;
//   port_rst, sys_ready, seq_state out (all registered)
module bringup_seq
  import bringup_pkg::*;
#(
  parameter int NUM_PORTS          = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 256,
  parameter int STAGGER_CYCLES     = 64
) (
  input logic clk,
  input logic rst,
  bringup_seq_if.slave bus
);
  localparam int CW = $clog2(max3(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES, STAGGER_CYCLES)) + 1;
  localparam logic [NUM_PORTS-1:0] ALL = '1;
  seq_state_e state;
  logic lock_s, lock_done, hold_done, stag_done, last_rel;
  logic [CW-1:0] cnt;
  logic [2:0] sel, pick;
  logic [NUM_PORTS-1:0] pending, pending_n, accept, pick_bit, sel_bit;
  sync_bit u_sync (.clk(clk), .rst(rst), .d(bus.pll_locked), .q(lock_s));
  assign bus.seq_state = state;
  // The WAIT_LOCK cycle that sees lock counts as the first stable cycle
  assign lock_done = int'(cnt) >= LOCK_STABLE_CYCLES - 2;
  assign hold_done = int'(cnt) == RST_HOLD_CYCLES - 1;
  assign stag_done = int'(cnt) == STAGGER_CYCLES - 1;
  assign last_rel  = int'(sel) == NUM_PORTS - 1;
  // Requests are only taken for ports out of their initial reset; the port
  // under re-reset may queue one more pulse
  always_comb begin
    accept = (state == RUN || state == REPORT) ? ALL : (state == RELEASE) ? ~bus.port_rst : '0;
    pick = lowest_idx(8'(pending));
    pick_bit = NUM_PORTS'(1) << pick;
    sel_bit = NUM_PORTS'(1) << sel;
    pending_n = (pending & ~((state == RUN) ? pick_bit : '0)) | (bus.port_rst_req & accept);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_LOCK;
      cnt <= '0;
      sel <= '0;
      pending <= '0;
      bus.port_rst <= ALL;
      bus.sys_ready <= 1'b0;
    end else if (!lock_s) begin
      state <= WAIT_LOCK;
      cnt <= '0;
      sel <= '0;
      pending <= '0;
      bus.port_rst <= ALL;
      bus.sys_ready <= 1'b0;
    end else begin
      pending <= pending_n;
      bus.sys_ready <= 1'b0;
      case (state)
        WAIT_LOCK: begin
          state <= LOCK_STABLE;
          cnt <= '0;
        end
        LOCK_STABLE: begin
          cnt <= lock_done ? '0 : cnt + 1'b1;
          state <= lock_done ? HOLD : LOCK_STABLE;
        end
        HOLD: begin
          cnt <= hold_done ? '0 : cnt + 1'b1;
          if (hold_done) begin
            state <= RELEASE;
            sel <= '0;
            bus.port_rst <= ALL << 1;
          end
        end
        RELEASE: begin
          cnt <= stag_done ? '0 : cnt + 1'b1;
          if (last_rel) begin
            state <= RUN;
            cnt <= '0;
            bus.sys_ready <= ~|pending_n;
          end else if (stag_done) begin
            sel <= sel + 1'b1;
            bus.port_rst <= bus.port_rst & ~(sel_bit << 1);
          end
        end
        RUN: begin
          if (|pending) begin
            state <= REPORT;
            sel <= pick;
            cnt <= '0;
            bus.port_rst <= pick_bit;
          end else begin
            bus.sys_ready <= ~|pending_n;
          end
        end
        REPORT: begin
          cnt <= hold_done ? '0 : cnt + 1'b1;
          if (hold_done) begin
            state <= RUN;
            bus.port_rst <= '0;
            bus.sys_ready <= ~|pending_n;
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end
endmodule

// File: tb/tb_bringup_seq.sv
// tb_bringup_seq: directed + random stimulus against a run-length reference model
module tb_bringup_seq;
  import bringup_pkg::*;
  localparam int N = 2, LSC = 8, RHC = 4, STG = 3;
  localparam int T = LSC + RHC;
  localparam int RUN_AT = T + (N - 1) * STG + 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0, n_fail = 0;
  bringup_seq_if #(.NUM_PORTS(N)) bus ();
  bringup_seq #(
    .NUM_PORTS(N), .LOCK_STABLE_CYCLES(LSC), .RST_HOLD_CYCLES(RHC), .STAGGER_CYCLES(STG)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic m_s1, m_s2;
  int run_len, busy, cur;
  logic [N-1:0] pend;
  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int thr(int i);
    return T + i * STG;
  endfunction
  function automatic int exp_rst();
    int v = 0;
    for (int i = 0; i < N; i++) if (run_len < thr(i) || (busy > 0 && cur == i)) v |= 1 << i;
    return v;
  endfunction
  function automatic int exp_ready();
    return (run_len >= RUN_AT && busy == 0 && pend == '0) ? 1 : 0;
  endfunction
  function automatic int exp_state();
    if (run_len == 0) return int'(WAIT_LOCK);
    if (run_len < LSC) return int'(LOCK_STABLE);
    if (run_len < T) return int'(HOLD);
    if (run_len < RUN_AT) return int'(RELEASE);
    return busy > 0 ? int'(REPORT) : int'(RUN);
  endfunction
  task automatic model_reset();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    run_len = 0;
    busy = 0;
    cur = 0;
    pend = '0;
  endtask
  // run_len = consecutive clock edges at which the synchronised lock was high
  task automatic model_edge(logic lock, logic [N-1:0] req);
    logic ls;
    int prev;
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = lock;
    if (!ls) begin
      run_len = 0;
      busy = 0;
      pend = '0;
    end else begin
      prev = run_len;
      run_len++;
      if (busy > 0) busy--;
      else if (prev >= RUN_AT && pend != '0) begin
        for (int i = N - 1; i >= 0; i--) if (pend[i]) cur = i;
        pend[cur] = 1'b0;
        busy = RHC;
      end
      for (int i = 0; i < N; i++) if (req[i] && prev >= thr(i)) pend[i] = 1'b1;
    end
  endtask
  task automatic check_outputs();
    chk("port_rst", int'(bus.port_rst), exp_rst());
    chk("sys_ready", int'(bus.sys_ready), exp_ready());
    chk("seq_state", int'(bus.seq_state), exp_state());
  endtask
  task automatic step(logic lock, logic [N-1:0] req);
    bus.pll_locked = lock;
    bus.port_rst_req = req;
    @(posedge clk);
    model_edge(lock, req);
    #1;
    check_outputs();
  endtask
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask
  initial begin
    int cyc;
    logic [N-1:0] rq;
    bus.pll_locked = 1'b1;
    bus.port_rst_req = '0;
    do_reset();
    cyc = 0;
    while (bus.port_rst[0] && cyc < 40) begin step(1'b1, '0); cyc++; end
    chk("rel0_latency", cyc, 2 + LSC + RHC);
    cyc = 0;
    while (bus.port_rst[1] && cyc < 40) begin step(1'b1, '0); cyc++; end
    chk("rel1_gap", cyc, STG);
    step(1'b1, '0);
    chk("ready_after_release", int'(bus.sys_ready), 1);
    step(1'b1, 2'b11);
    repeat (14) step(1'b1, '0);
    chk("ready_after_rereset", int'(bus.sys_ready), 1);
    step(1'b1, 2'b01);
    step(1'b1, '0);
    step(1'b1, 2'b01);
    repeat (16) step(1'b1, '0);
    repeat (3) step(1'b0, '0);
    chk("drop_port_rst", int'(bus.port_rst), 3);
    chk("drop_ready", int'(bus.sys_ready), 0);
    repeat (20) step(1'b1, '0);
    chk("relock_ready", int'(bus.sys_ready), 1);
    repeat (3) step(1'b0, '0);
    cyc = 0;
    while (run_len != 5 && cyc < 40) begin step(1'b1, '0); cyc++; end
    step(1'b0, '0);
    cyc = 0;
    while (bus.port_rst[0] && cyc < 40) begin step(1'b1, '0); cyc++; end
    chk("glitch_restart", cyc, 2 + LSC + RHC);
    repeat (6) step(1'b1, '0);
    do_reset();
    cyc = 0;
    while (exp_state() != int'(HOLD) && cyc < 40) begin step(1'b1, '0); cyc++; end
    step(1'b1, 2'b10);
    repeat (12) step(1'b1, '0);
    chk("hold_req_ignored", int'(bus.seq_state), int'(RUN));
    do_reset();
    cyc = 0;
    while (exp_state() != int'(RELEASE) && cyc < 40) begin step(1'b1, '0); cyc++; end
    chk("mid_release_reached", int'(bus.seq_state), int'(RELEASE));
    do_reset();
    for (int k = 0; k < 800; k++) begin
      for (int b = 0; b < N; b++) rq[b] = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 249) != 0, rq);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
